// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the fetch/data RAM port arbiter
// Purpose: FSM state and grant encodings plus the round-robin grant helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
  typedef enum logic {GNT_IF, GNT_DATA} arb_grant_t;

  // On a collision the winner alternates against the last collision winner;
  // a lone requester always wins.
  function automatic arb_grant_t pick_grant(input logic if_req, input logic d_req,
                                            input arb_grant_t last_grant);
    if (if_req && d_req) begin
      return (last_grant == GNT_IF) ? GNT_DATA : GNT_IF;
    end else if (d_req) begin
      return GNT_DATA;
    end
    return GNT_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and RAM signal bundle for the port arbiter
// Purpose: groups fetch, load/store and RAM-side signals.
// Ports: slave modport = arbiter side, master modport = core/RAM side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_done, d_rdata, d_done, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_done, d_rdata, d_done, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// rtl/mem_port_arbiter_wait_counter.sv - RAM access wait-cycle counter
// Purpose: counts 0..MAX-1 while en is high and flags the final access cycle.
// Ports: clk, reset_n (async active-low), en (count enable), last (final cycle flag).
module wait_counter #(
  parameter int MAX = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic last
);
  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last = en && (cnt_q == CNT_LAST);

  // Wrapping to zero on the last cycle keeps the counter ready for the next access.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one RAM port between fetch and load/store requesters
// Purpose: grants one requester, holds the RAM access for WAIT_CYCLES, returns data and a done pulse.
// Ports: clk, reset_n (async active-low), bus (mem_port_arbiter_if.slave: requester + RAM signals).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_port_arbiter_if.slave   bus
);
  arb_state_t        state_q, state_d;
  arb_grant_t        grant_q, grant_d;
  arb_grant_t        last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              acc_last;

  wait_counter #(.MAX(WAIT_CYCLES)) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state_q == ACCESS),
    .last    (acc_last)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          grant_d = pick_grant(bus.if_req, bus.d_req, last_q);
          // Only collisions move the round-robin pointer.
          if (bus.if_req && bus.d_req) begin
            last_d = grant_d;
          end
          addr_d  = (grant_d == GNT_DATA) ? bus.d_addr : bus.if_addr;
          wdata_d = (grant_d == GNT_DATA) ? bus.d_wdata : '0;
          we_d    = (grant_d == GNT_DATA) && bus.d_we;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (acc_last) begin
          if (grant_q == GNT_IF) begin
            if_rdata_d = bus.mem_rdata;
          end else if (!we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= GNT_IF;
      last_q     <= GNT_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // RAM strobes decode straight from state so an async reset drops them at once.
  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_done   = (state_q == DONE) && (grant_q == GNT_IF);
  assign bus.d_done    = (state_q == DONE) && (grant_q == GNT_DATA);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if ifc2 ();
  mem_port_arbiter_if ifc1 ();
  mem_port_arbiter_if ifc15 ();

  mem_port_arbiter #(.WAIT_CYCLES(2))  dut   (.clk(clk), .reset_n(rst_n), .bus(ifc2.slave));
  mem_port_arbiter #(.WAIT_CYCLES(1))  dut1  (.clk(clk), .reset_n(rst_n), .bus(ifc1.slave));
  mem_port_arbiter #(.WAIT_CYCLES(15)) dut15 (.clk(clk), .reset_n(rst_n), .bus(ifc15.slave));

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0000) + 32'h0000_1111);
  endfunction

  assign ifc2.mem_rdata  = ram_word(ifc2.mem_addr);
  assign ifc1.mem_rdata  = 32'h1111_0001;
  assign ifc15.mem_rdata = 32'hF00D_0015;

  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          done_cyc;
  } exp_t;

  exp_t        sb[$];
  int          q1[$];
  int          q15[$];
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_d_rdata  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic push_exp(input logic is_data, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int done_cyc);
    exp_t e;
    e.is_data = is_data; e.we = we; e.addr = addr; e.wdata = wdata; e.done_cyc = done_cyc;
    if (!is_data) begin
      m_if_rdata = ram_word(addr);
      e.rdata = m_if_rdata;
    end else if (!we) begin
      m_d_rdata = ram_word(addr);
      e.rdata = m_d_rdata;
    end else begin
      e.rdata = m_d_rdata;
    end
    sb.push_back(e);
  endtask

  // Main scoreboard monitor: RAM bus against the in-flight access, done pulses against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc2.mem_en) begin
        if (sb.size() == 0) begin
          check("mem_en_unexpected", 32'd1, 32'd0);
        end else begin
          check("mem_addr", ifc2.mem_addr, sb[0].addr);
          check("mem_we", {31'd0, ifc2.mem_we}, {31'd0, sb[0].we});
          if (sb[0].we) check("mem_wdata", ifc2.mem_wdata, sb[0].wdata);
        end
      end else if (ifc2.mem_we) begin
        check("mem_we_without_en", 32'd1, 32'd0);
      end
      if (ifc2.if_done && ifc2.d_done) begin
        check("both_done", 32'd1, 32'd0);
      end else if (ifc2.if_done || ifc2.d_done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_port", {31'd0, ifc2.d_done}, {31'd0, e.is_data});
          check("done_cycle", cyc, e.done_cyc);
          check(e.is_data ? "d_rdata" : "if_rdata",
                e.is_data ? ifc2.d_rdata : ifc2.if_rdata, e.rdata);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ifc1.d_done) begin
      if (q1.size() == 0) check("w1_spurious_done", 32'd1, 32'd0);
      else begin
        check("w1_done_cycle", cyc, q1.pop_front());
        check("w1_d_rdata", ifc1.d_rdata, 32'h1111_0001);
      end
    end
    if (rst_n && ifc15.d_done) begin
      if (q15.size() == 0) check("w15_spurious_done", 32'd1, 32'd0);
      else begin
        check("w15_done_cycle", cyc, q15.pop_front());
        check("w15_d_rdata", ifc15.d_rdata, 32'hF00D_0015);
      end
    end
  end

  task automatic wait_done(input logic is_data, input int budget);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      seen = is_data ? ifc2.d_done : ifc2.if_done;
    end
    check(is_data ? "d_done_seen" : "if_done_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    if (is_data) ifc2.d_req = 1'b0;
    else ifc2.if_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    m_if_rdata = '0;
    m_d_rdata  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue_if(input logic [31:0] addr);
    ifc2.if_addr = addr;
    ifc2.if_req  = 1'b1;
  endtask

  task automatic issue_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    ifc2.d_we    = we;
    ifc2.d_addr  = addr;
    ifc2.d_wdata = wdata;
    ifc2.d_req   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic s1, s15;
    ifc2.if_req = 0; ifc2.if_addr = 0; ifc2.d_req = 0; ifc2.d_we = 0; ifc2.d_addr = 0; ifc2.d_wdata = 0;
    ifc1.if_req = 0; ifc1.if_addr = 0; ifc1.d_req = 0; ifc1.d_we = 0; ifc1.d_addr = 0; ifc1.d_wdata = 0;
    ifc15.if_req = 0; ifc15.if_addr = 0; ifc15.d_req = 0; ifc15.d_we = 0; ifc15.d_addr = 0; ifc15.d_wdata = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", {31'd0, ifc2.mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, ifc2.mem_we}, 32'd0);
    check("rst_busy", {31'd0, ifc2.busy}, 32'd0);
    check("rst_if_done", {31'd0, ifc2.if_done}, 32'd0);
    check("rst_d_done", {31'd0, ifc2.d_done}, 32'd0);
    check("rst_if_rdata", ifc2.if_rdata, 32'd0);
    check("rst_d_rdata", ifc2.d_rdata, 32'd0);
    check("rst_mem_addr", ifc2.mem_addr, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // T1: single fetch
    @(posedge clk); #1;
    push_exp(1'b0, 1'b0, 32'h40, 32'h0, cyc + 3);
    issue_if(32'h40);
    wait_done(1'b0, 10);

    // Load so that the following store can show d_rdata is left alone
    push_exp(1'b1, 1'b0, 32'h200, 32'h0, cyc + 3);
    issue_d(1'b0, 32'h200, 32'h0);
    wait_done(1'b1, 10);

    // T2: store
    push_exp(1'b1, 1'b1, 32'h100, 32'h12345678, cyc + 3);
    issue_d(1'b1, 32'h100, 32'h12345678);
    wait_done(1'b1, 10);
    ifc2.d_we = 1'b0;

    // T3: collisions after reset alternate DATA, IF then IF, DATA
    do_reset();
    @(posedge clk); #1;
    push_exp(1'b1, 1'b0, 32'h300, 32'h0, cyc + 3);
    push_exp(1'b0, 1'b0, 32'h44, 32'h0, cyc + 7);
    issue_if(32'h44);
    issue_d(1'b0, 32'h300, 32'h0);
    wait_done(1'b1, 10);
    wait_done(1'b0, 10);
    push_exp(1'b0, 1'b0, 32'h48, 32'h0, cyc + 3);
    push_exp(1'b1, 1'b0, 32'h304, 32'h0, cyc + 7);
    issue_if(32'h48);
    issue_d(1'b0, 32'h304, 32'h0);
    wait_done(1'b0, 10);
    wait_done(1'b1, 10);

    // T4: reset during ACCESS aborts the fetch
    push_exp(1'b0, 1'b0, 32'h80, 32'h0, cyc + 3);
    issue_if(32'h80);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_en", {31'd0, ifc2.mem_en}, 32'd0);
    check("abort_mem_we", {31'd0, ifc2.mem_we}, 32'd0);
    check("abort_busy", {31'd0, ifc2.busy}, 32'd0);
    ifc2.if_req = 1'b0;
    sb.delete();
    m_if_rdata = '0;
    m_d_rdata  = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    push_exp(1'b1, 1'b0, 32'h500, 32'h0, cyc + 3);
    issue_d(1'b0, 32'h500, 32'h0);
    wait_done(1'b1, 10);

    // T6: inputs changed and request dropped mid-access
    push_exp(1'b0, 1'b0, 32'h84, 32'h0, cyc + 3);
    issue_if(32'h84);
    @(negedge clk);
    @(negedge clk);
    #1;
    ifc2.if_addr = 32'h999;
    ifc2.if_req  = 1'b0;
    wait_done(1'b0, 10);
    repeat (6) @(negedge clk);

    // T5: WAIT_CYCLES = 1 and 15
    @(posedge clk); #1;
    q1.push_back(cyc + 2);
    q15.push_back(cyc + 16);
    ifc1.d_addr = 32'h10;  ifc1.d_req = 1'b1;
    ifc15.d_addr = 32'h20; ifc15.d_req = 1'b1;
    s1 = 1'b0; s15 = 1'b0;
    for (int n = 0; n < 40 && !(s1 && s15); n++) begin
      @(negedge clk);
      if (ifc1.d_done) s1 = 1'b1;
      if (ifc15.d_done) s15 = 1'b1;
      @(posedge clk); #1;
      if (s1) ifc1.d_req = 1'b0;
      if (s15) ifc15.d_req = 1'b0;
    end
    check("w1_done_seen", {31'd0, s1}, 32'd1);
    check("w15_done_seen", {31'd0, s15}, 32'd1);

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    check("q15_drained", q15.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
